// File: rtl/rate_div_counter_gen_pkg.sv
// rate_div_counter_gen_pkg: speed encodings and default divider settings for rate_div_counter_gen
package rate_div_counter_gen_pkg;
  localparam logic [1:0] SPD_0 = 2'b00;
  localparam logic [1:0] SPD_1 = 2'b01;
  localparam logic [1:0] SPD_2 = 2'b10;
  localparam logic [1:0] SPD_3 = 2'b11;
  localparam int DIV_W_DEF = 11;
  localparam int DIV0_DEF = 0;
  localparam int DIV1_DEF = 499;
  localparam int DIV2_DEF = 999;
  localparam int DIV3_DEF = 1999;
endpackage

// File: rtl/rate_divider_gen.sv
// rate_divider_gen: speed-selected down-counting divider producing a one-cycle tick_en
module rate_divider_gen
  import rate_div_counter_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DIV0 = DIV0_DEF,
  parameter int DIV1 = DIV1_DEF,
  parameter int DIV2 = DIV2_DEF,
  parameter int DIV3 = DIV3_DEF
) (
  input  logic       ClockIn,
  input  logic       Clear_b,
  input  logic       Enable,
  input  logic       Load,
  input  logic [1:0] Speed,
  output logic       tick_en
);
  logic [DIV_W-1:0] div, reload;
  logic [1:0] speed_q;
  if (DIV0 < 0 || DIV1 < 0 || DIV2 < 0 || DIV3 < 0 ||
      DIV0 >= 2**DIV_W || DIV1 >= 2**DIV_W || DIV2 >= 2**DIV_W || DIV3 >= 2**DIV_W) begin : g_bad_div
    $error("rate_divider_gen: reload value does not fit in DIV_W bits");
  end
  always_comb begin
    case (Speed)
      SPD_0:   reload = DIV_W'(DIV0);
      SPD_1:   reload = DIV_W'(DIV1);
      SPD_2:   reload = DIV_W'(DIV2);
      SPD_3:   reload = DIV_W'(DIV3);
      default: reload = DIV_W'(DIV3);
    endcase
  end
  // a speed change restarts the period without stepping the counter
  assign tick_en = Clear_b && !Load && Enable && Speed == speed_q && div == '0;
  always_ff @(posedge ClockIn) begin
    speed_q <= Speed;
    if (!Clear_b) div <= '0;
    else if (Load || (Enable && (Speed != speed_q || div == '0))) div <= reload;
    else if (Enable) div <= div - DIV_W'(1);
  end
endmodule

// File: rtl/rate_div_counter_gen.sv
// rate_div_counter_gen: rate-divided up/down counter with load, run/pause, Tick and Wrap pulses
// CNT_SAT_EN: when defined the counter saturates at its ends instead of wrapping
module rate_div_counter_gen
  import rate_div_counter_gen_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DIV0 = DIV0_DEF,
  parameter int DIV1 = DIV1_DEF,
  parameter int DIV2 = DIV2_DEF,
  parameter int DIV3 = DIV3_DEF
) (
  input  logic             ClockIn,
  input  logic             Clear_b,
  input  logic             Enable,
  input  logic [1:0]       Speed,
  input  logic             Up,
  input  logic             Load,
  input  logic [CNT_W-1:0] LoadValue,
  output logic [CNT_W-1:0] CounterValue,
  output logic             Tick,
  output logic             Wrap
);
`ifdef CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic tick_en, at_end;
  rate_divider_gen #(
    .DIV_W(DIV_W), .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3)
  ) u_div (
    .ClockIn(ClockIn),
    .Clear_b(Clear_b),
    .Enable(Enable),
    .Load(Load),
    .Speed(Speed),
    .tick_en(tick_en)
  );
  assign at_end = Up ? &CounterValue : ~|CounterValue;
  always_ff @(posedge ClockIn) begin
    if (!Clear_b) begin
      CounterValue <= '0;
      Tick <= 1'b0;
      Wrap <= 1'b0;
    end else if (Load) begin
      CounterValue <= LoadValue;
      Tick <= 1'b0;
      Wrap <= 1'b0;
    end else begin
      Tick <= tick_en;
      Wrap <= tick_en && at_end;
      if (tick_en && !(SAT && at_end))
        CounterValue <= Up ? CounterValue + CNT_W'(1) : CounterValue - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_rate_div_counter_gen.sv
// tb_rate_div_counter_gen: scoreboard bench for rate_div_counter_gen against a cycles-until-tick model
module tb_rate_div_counter_gen;
  logic ClockIn = 1'b0;
  logic Clear_b, Enable, Up, Load;
  logic [1:0] Speed;
  logic [3:0] LoadValue, CounterValue;
  logic Tick, Wrap;
  int n_vec = 0, n_err = 0;
  typedef struct {int cnt; bit tick; bit wrap;} exp_t;
  exp_t sb[$];
  int mcnt, mrem, mspd;
  bit mtick, mwrap;

  always #5 ClockIn = ~ClockIn;

  rate_div_counter_gen dut (
    .ClockIn(ClockIn),
    .Clear_b(Clear_b),
    .Enable(Enable),
    .Speed(Speed),
    .Up(Up),
    .Load(Load),
    .LoadValue(LoadValue),
    .CounterValue(CounterValue),
    .Tick(Tick),
    .Wrap(Wrap)
  );

  function automatic int period_m1(int s);
    return s == 0 ? 0 : s == 1 ? 499 : s == 2 ? 999 : 1999;
  endfunction

  // mrem = enabled cycles still to wait before the next step
  task automatic cyc();
    int nxt;
    if (!Clear_b) begin
      mcnt = 0; mrem = 0; mtick = 0; mwrap = 0;
    end else if (Load) begin
      mcnt = LoadValue; mrem = period_m1(Speed); mtick = 0; mwrap = 0;
    end else if (Enable && Speed != mspd) begin
      mrem = period_m1(Speed); mtick = 0; mwrap = 0;
    end else if (!Enable || mrem > 0) begin
      if (Enable) mrem = mrem - 1;
      mtick = 0; mwrap = 0;
    end else begin
      mrem = period_m1(Speed);
      nxt = mcnt + (Up ? 1 : -1);
      mtick = 1;
      mwrap = nxt < 0 || nxt > 15;
`ifdef CNT_SAT_EN
      mcnt = nxt < 0 ? 0 : nxt > 15 ? 15 : nxt;
`else
      mcnt = (nxt + 16) % 16;
`endif
    end
    mspd = Speed;
    @(posedge ClockIn);
    sb.push_back('{mcnt, mtick, mwrap});
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic wait_rem(string nm, int r);
    for (int i = 0; i < 3000 && mrem != r; i++) cyc();
    chk(nm, mrem, r);
  endtask

  task automatic cycles_to_tick(string nm, int want);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!Tick && n < 2500);
    chk(nm, n, want);
  endtask

  always @(negedge ClockIn) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (CounterValue !== 4'(e.cnt) || Tick !== e.tick || Wrap !== e.wrap) begin
        n_err++;
        $display("FAIL scoreboard @%0t: got cnt=%h tick=%b wrap=%b, expected cnt=%h tick=%b wrap=%b",
                 $time, CounterValue, Tick, Wrap, 4'(e.cnt), e.tick, e.wrap);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int wraps;
    logic [3:0] hold;
    Clear_b = 0; Enable = 0; Speed = 0; Up = 1; Load = 0; LoadValue = 0; mspd = 0;
    cyc();
    chk("reset cnt", CounterValue, 0);
    chk("reset tick", Tick, 0);
    chk("reset wrap", Wrap, 0);
    Clear_b = 1; Enable = 1;
    wraps = 0;
    repeat (20) begin
      cyc();
      wraps += int'(Wrap);
    end
`ifdef CNT_SAT_EN
    chk("t1 cnt", CounterValue, 15);
    chk("t1 wraps", wraps, 5);
`else
    chk("t1 cnt", CounterValue, 4);
    chk("t1 wraps", wraps, 1);
`endif
    Clear_b = 0; Speed = 1;
    cyc();
    Clear_b = 1;
    cyc();
    chk("t2 first tick", Tick, 1);
    repeat (1000) cyc();
    chk("t2 cnt", CounterValue, 3);
    wait_rem("t3 reach", 200);
    Speed = 3;
    cyc();
    chk("t3 no step", Tick, 0);
    cycles_to_tick("t3 period", 2000);
    Enable = 0; Load = 1; LoadValue = 4'hE; Speed = 0;
    cyc();
    Load = 0; Enable = 1; Up = 1;
    cyc();
    cyc();
`ifdef CNT_SAT_EN
    chk("t4 up cnt", CounterValue, 4'hF);
`else
    chk("t4 up cnt", CounterValue, 4'h0);
`endif
    chk("t4 up wrap", Wrap, 1);
    Enable = 0; Load = 1; LoadValue = 4'h1;
    cyc();
    Load = 0; Enable = 1; Up = 0;
    cyc();
    cyc();
`ifdef CNT_SAT_EN
    chk("t4 dn cnt", CounterValue, 4'h0);
`else
    chk("t4 dn cnt", CounterValue, 4'hF);
`endif
    chk("t4 dn wrap", Wrap, 1);
    Speed = 2; Up = 1;
    wait_rem("t5 reach", 100);
    Enable = 0;
    hold = CounterValue;
    repeat (37) cyc();
    chk("t5 frozen", CounterValue, hold);
    Enable = 1;
    cycles_to_tick("t5 resume", 101);
    Speed = 0;
    cyc();
    Clear_b = 0; Load = 1; LoadValue = 4'h9;
    cyc();
    chk("t6 cnt", CounterValue, 0);
    chk("t6 tick", Tick, 0);
    chk("t6 wrap", Wrap, 0);
    Clear_b = 1; Load = 0; Up = 1;
    cyc();
    chk("t6 next tick", Tick, 1);
    chk("t6 next cnt", CounterValue, 1);
    repeat (3000) begin
      Clear_b = $urandom_range(0, 99) != 0;
      Load = $urandom_range(0, 29) == 0;
      LoadValue = 4'($urandom);
      Enable = $urandom_range(0, 7) != 0;
      Up = 1'($urandom);
      if ($urandom_range(0, 19) == 0)
        Speed = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cyc();
    end
    @(negedge ClockIn);
    #1;
    chk("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
